// File: rtl/qupls_rename_src_a_pkg.sv
// qupls_rename_src_a_pkg: widths, register/tag types and the rename entry carried through the skid buffer
package qupls_rename_src_a_pkg;
  localparam int AREG_W = 7;
  localparam int PREG_W = 9;
  localparam int TAG_W = 8;
  typedef logic [AREG_W-1:0] aregno_t;
  typedef logic [PREG_W-1:0] pregno_t;
  typedef logic [TAG_W-1:0] seqtag_t;
  localparam aregno_t AREG_ZERO = '0;
  typedef struct packed {
    pregno_t Pa;
    seqtag_t tag;
    logic byp;
  } rn_ent_t;
endpackage

// File: rtl/qupls_rename_src_a_if.sv
// qupls_rename_src_a_if: capture handshake, map write port and output handshake of the source-A rename stage
//  master drives in_valid/in_Ra/in_tag, wr_en/wr_areg/wr_preg, out_ready; slave drives in_ready, out_valid/out_Pa/out_tag/out_byp
interface qupls_rename_src_a_if;
  import qupls_rename_src_a_pkg::*;
  logic in_valid;
  logic in_ready;
  aregno_t in_Ra;
  seqtag_t in_tag;
  logic wr_en;
  aregno_t wr_areg;
  pregno_t wr_preg;
  logic out_valid;
  logic out_ready;
  pregno_t out_Pa;
  seqtag_t out_tag;
  logic out_byp;
  modport master (
    output in_valid, in_Ra, in_tag, wr_en, wr_areg, wr_preg, out_ready,
    input in_ready, out_valid, out_Pa, out_tag, out_byp
  );
  modport slave (
    input in_valid, in_Ra, in_tag, wr_en, wr_areg, wr_preg, out_ready,
    output in_ready, out_valid, out_Pa, out_tag, out_byp
  );
endinterface

// File: rtl/qupls_skid2.sv
// qupls_skid2: 2-entry registered valid/ready FIFO of rename entries with synchronous flush
//  clk/rst_n clock and async active-low reset; flush drops all entries and any same-cycle push
//  in_valid/in_ready/in_data push side; out_valid/out_ready/out_data pop side (out_data is the head register)
module qupls_skid2
  import qupls_rename_src_a_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  logic    in_valid,
  output logic    in_ready,
  input  rn_ent_t in_data,
  output logic    out_valid,
  input  logic    out_ready,
  output rn_ent_t out_data
);
  logic [1:0] cnt;
  rn_ent_t e0, e1;
  logic push, pop;
  assign in_ready = cnt < 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_data = e0;
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      cnt <= flush ? 2'd0 : cnt + 2'(push) - 2'(pop);
      // a push lands in the head slot when the FIFO is empty or the head leaves this cycle
      if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) e0 <= in_data;
      else if (pop && cnt == 2'd2) e0 <= e1;
      if (push && cnt == 2'd1 && !pop) e1 <= in_data;
    end
endmodule

// File: rtl/qupls_rename_src_a.sv
// qupls_rename_src_a: renames architectural source A to a physical tag through a 128-entry speculative map
//  clk clock; rst_n async active-low reset (identity map, empty buffer); flush_i drops in-flight entries
//  bus.slave: in_valid/in_ready/in_Ra/in_tag capture, wr_en/wr_areg/wr_preg map update,
//  out_valid/out_ready/out_Pa/out_tag/out_byp registered result
module qupls_rename_src_a
  import qupls_rename_src_a_pkg::*;
(
  input logic clk,
  input logic rst_n,
  input logic flush_i,
  qupls_rename_src_a_if.slave bus
);
  pregno_t map [2**AREG_W];
  rn_ent_t ent, head;
  logic byp;
  // the same-cycle write is older in program order, so it wins over the table
  assign byp = bus.wr_en && bus.wr_areg == bus.in_Ra && bus.in_Ra != AREG_ZERO;
  always_comb begin
    ent.Pa = bus.in_Ra == AREG_ZERO ? pregno_t'(0) : byp ? bus.wr_preg : map[bus.in_Ra];
    ent.tag = bus.in_tag;
    ent.byp = byp;
  end
  // register 0 is hardwired; writes to it are dropped so map[0] stays 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 2**AREG_W; i++) map[i] <= PREG_W'(i);
    else if (bus.wr_en && bus.wr_areg != AREG_ZERO) map[bus.wr_areg] <= bus.wr_preg;
  qupls_skid2 u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush_i),
    .in_valid(bus.in_valid),
    .in_ready(bus.in_ready),
    .in_data(ent),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data(head)
  );
  assign bus.out_Pa = head.Pa;
  assign bus.out_tag = head.tag;
  assign bus.out_byp = head.byp;
endmodule

// File: tb/tb_qupls_rename_src_a.sv
// tb_qupls_rename_src_a: directed and random checks of the source-A rename stage against a map/queue model
module tb_qupls_rename_src_a;
  import qupls_rename_src_a_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  always #5 clk = ~clk;
  qupls_rename_src_a_if bus ();
  qupls_rename_src_a dut (.clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(bus));
  pregno_t rmap [2**AREG_W];
  rn_ent_t q[$];
  int nvec = 0;
  int nerr = 0;
  seqtag_t tg = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2**AREG_W; i++) rmap[i] = PREG_W'(i);
    q.delete();
  endtask

  task automatic drive(logic v, aregno_t ra, seqtag_t t, logic we, aregno_t wa, pregno_t wp, logic ordy, logic fl);
    bus.in_valid = v;
    bus.in_Ra = ra;
    bus.in_tag = t;
    bus.wr_en = we;
    bus.wr_areg = wa;
    bus.wr_preg = wp;
    bus.out_ready = ordy;
    flush = fl;
  endtask

  // called just after a negedge with inputs driven; checks outputs, then advances the model across the posedge
  task automatic step();
    rn_ent_t e;
    logic cap, pop;
    #1;
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_Pa", bus.out_Pa, q[0].Pa);
      chk("out_tag", bus.out_tag, q[0].tag);
      chk("out_byp", bus.out_byp, q[0].byp);
    end
    cap = bus.in_valid && q.size() < 2 && !flush;
    pop = q.size() > 0 && bus.out_ready;
    e.byp = bus.in_Ra != 0 && bus.wr_en && bus.wr_areg == bus.in_Ra;
    e.Pa = bus.in_Ra == 0 ? pregno_t'(0) : e.byp ? bus.wr_preg : rmap[bus.in_Ra];
    e.tag = bus.in_tag;
    @(posedge clk);
    if (pop) q.delete(0);
    if (flush) q.delete();
    else if (cap) q.push_back(e);
    if (bus.wr_en && bus.wr_areg != 0) rmap[bus.wr_areg] = bus.wr_preg;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      step();
    end
  endtask

  initial begin
    reset_model();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_Pa", bus.out_Pa, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_byp", bus.out_byp, 0);
    rst_n = 1;
    drive(1, 5, 1, 0, 0, 0, 1, 0); step();
    idle(1);
    drive(0, 0, 0, 1, 5, 200, 1, 0); step();
    drive(1, 5, 2, 0, 0, 0, 1, 0); step();
    drive(1, 5, 3, 1, 5, 201, 1, 0); step();
    drive(1, 127, 4, 1, 64, 511, 1, 0); step();
    drive(0, 0, 0, 1, 0, 77, 1, 0); step();
    drive(1, 0, 5, 0, 0, 0, 1, 0); step();
    drive(1, 0, 6, 1, 0, 88, 1, 0); step();
    idle(2);
    drive(1, 5, 10, 0, 0, 0, 0, 0); step();
    drive(1, 9, 11, 0, 0, 0, 0, 0); step();
    drive(1, 5, 12, 1, 5, 300, 0, 0); step();
    drive(0, 0, 0, 1, 9, 301, 0, 0); step();
    idle(3);
    drive(1, 5, 20, 0, 0, 0, 1, 0); step();
    drive(1, 64, 21, 0, 0, 0, 1, 0); step();
    idle(2);
    drive(1, 3, 30, 0, 0, 0, 0, 0); step();
    drive(1, 4, 31, 0, 0, 0, 0, 0); step();
    drive(1, 6, 32, 1, 7, 123, 0, 1); step();
    drive(1, 7, 33, 0, 0, 0, 1, 0); step();
    idle(2);
    drive(1, 3, 40, 0, 0, 0, 0, 0); step();
    drive(1, 4, 41, 0, 0, 0, 0, 1); step();
    idle(2);
    drive(1, 11, 50, 1, 11, 400, 0, 0); step();
    drive(1, 12, 51, 1, 12, 401, 0, 0); step();
    rst_n = 0;
    reset_model();
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_Pa", bus.out_Pa, 0);
    @(negedge clk);
    rst_n = 1;
    drive(1, 11, 52, 0, 0, 0, 1, 0); step();
    drive(1, 12, 53, 0, 0, 0, 1, 0); step();
    idle(1);
    for (int n = 0; n < 1000; n++) begin
      aregno_t ra, wa;
      ra = ($urandom % 4 == 0) ? aregno_t'($urandom) : aregno_t'($urandom % 8);
      wa = ($urandom % 4 == 0) ? aregno_t'($urandom) : aregno_t'($urandom % 8);
      drive(1'($urandom), ra, tg, 1'($urandom), wa, pregno_t'($urandom), $urandom % 3 != 0, $urandom % 50 == 0);
      tg++;
      step();
    end
    idle(4);
    chk("drained", bus.out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
